// File: rtl/srl_pkg.sv
// Shared constants and helpers for the SRL delay bank.
//   SRL_SEG     : depth of one SRL primitive segment
//   MAX_DEPTH   : deepest legal delay line
//   clog2()     : address width helper usable in parameter/port declarations
//   depth_legal(): true for the supported line depths (32, 64, 128)
//   tap_out_t   : per-line masked output bundle
package srl_pkg;

    localparam int SRL_SEG   = 32;
    localparam int SEG_AW    = 5;
    localparam int MAX_DEPTH = 128;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    function automatic bit depth_legal(input int depth);
        return (depth == 32) || (depth == 64) || (depth == MAX_DEPTH);
    endfunction

    typedef struct packed {
        logic q;
        logic q_valid;
        logic q_last;
    } tap_out_t;

endpackage

// File: rtl/srl_chain_ch.sv
// One delay line built from cascaded 32-deep SRL segments. No reset: the
// storage models SRL primitives, which have none.
//   clk    : shift clock
//   ce     : shift enable
//   d      : serial input (becomes element 0)
//   a      : tap address; a[AW-1:5] picks the segment, a[4:0] the bit in it
//   q      : element a of the line (unmasked)
//   q_last : element DEPTH-1 of the line (unmasked)
module srl_chain_ch
    import srl_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = clog2(DEPTH)
)(
    input  logic          clk,
    input  logic          ce,
    input  logic          d,
    input  logic [AW-1:0] a,
    output logic          q,
    output logic          q_last
);

    localparam int NSEG = DEPTH / SRL_SEG;

    // seg[s][k] holds line element s*32 + k
    logic [SRL_SEG-1:0] seg [NSEG];

    for (genvar s = 0; s < NSEG; s++) begin : g_seg
        logic seg_in;
        if (s == 0) begin : g_head
            assign seg_in = d;
        end else begin : g_cascade
            // Q31 of the previous segment feeds this one
            assign seg_in = seg[s-1][SRL_SEG-1];
        end

        always_ff @(posedge clk) begin
            if (ce) seg[s] <= {seg[s][SRL_SEG-2:0], seg_in};
        end
    end

    if (NSEG == 1) begin : g_tap_single
        assign q = seg[0][a[SEG_AW-1:0]];
    end else begin : g_tap_multi
        logic [AW-SEG_AW-1:0] seg_sel;
        assign seg_sel = a[AW-1:SEG_AW];
        assign q       = seg[seg_sel][a[SEG_AW-1:0]];
    end

    assign q_last = seg[NSEG-1][SRL_SEG-1];

endmodule

// File: rtl/srl_delay_bank.sv
// Bank of NUM_CH addressable SRL delay lines sharing clock, CE and reset.
// A shared fill counter masks each tap until it holds post-reset data.
//   CLK     : clock, rising edge
//   RST     : asynchronous active-high reset (control/output state only)
//   CE      : shift enable for all lines
//   D       : serial input, bit c feeds line c
//   A       : tap address(es); shared A[AW-1:0] or per line A[c*AW +: AW]
//   Q       : masked selected tap per line
//   Q_VALID : tap of line c holds data shifted in since reset
//   Q_LAST  : masked last tap (DEPTH-1), nonzero only once the line is full
module srl_delay_bank
    import srl_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int DEPTH       = 64,
    parameter int OUT_REG     = 1,
    parameter int SHARED_ADDR = 1
)(
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             CE,
    input  logic [NUM_CH-1:0]                D,
    input  logic [NUM_CH*clog2(DEPTH)-1:0]   A,
    output logic [NUM_CH-1:0]                Q,
    output logic [NUM_CH-1:0]                Q_VALID,
    output logic [NUM_CH-1:0]                Q_LAST
);

    localparam int AW        = clog2(DEPTH);
    localparam bit PARAMS_OK = depth_legal(DEPTH) && (NUM_CH >= 1) && (NUM_CH <= 8);
    localparam logic [AW:0] FILL_MAX = (AW+1)'(DEPTH);

    if (!PARAMS_OK) begin : g_bad_param
        $error("srl_delay_bank: DEPTH must be 32/64/128 and NUM_CH 1..8");
    end

    // Fill counter: number of shifts since reset, saturating at DEPTH.
    logic [AW:0] fill;
    logic        full;

    assign full = (fill == FILL_MAX);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)              fill <= '0;
        else if (CE && !full) fill <= fill + 1'b1;
    end

    tap_out_t [NUM_CH-1:0] mask;
    tap_out_t [NUM_CH-1:0] out_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [AW-1:0] a_c;
        logic          tap;
        logic          last;
        logic          valid;

        if (SHARED_ADDR != 0) begin : g_shared
            assign a_c = A[AW-1:0];
        end else begin : g_own
            assign a_c = A[c*AW +: AW];
        end

        srl_chain_ch #(
            .DEPTH (DEPTH),
            .AW    (AW)
        ) u_chain (
            .clk    (CLK),
            .ce     (CE),
            .d      (D[c]),
            .a      (a_c),
            .q      (tap),
            .q_last (last)
        );

        // Element a_c is post-reset data once more than a_c shifts happened.
        assign valid   = (fill > {1'b0, a_c});
        // AND-masking keeps never-written (unknown) storage from reaching Q.
        assign mask[c] = tap_out_t'{q: valid & tap, q_valid: valid, q_last: full & last};

        assign Q[c]       = out_q[c].q;
        assign Q_VALID[c] = out_q[c].q_valid;
        assign Q_LAST[c]  = out_q[c].q_last;
    end

    if (OUT_REG != 0) begin : g_out_reg
        // Free-running output register: captures the mask every edge, CE or not.
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) out_q <= '0;
            else     out_q <= mask;
        end
    end else begin : g_out_comb
        assign out_q = mask;
    end

endmodule

// File: tb/tb_srl_delay_bank.sv
// Bench for srl_delay_bank: dut_a = 2 lines, DEPTH 64, registered, shared
// address; dut_b = 2 lines, DEPTH 128, combinational, per-line address.
module tb_srl_delay_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, ce;
    logic [1:0]  d;
    logic [11:0] a_a;
    logic [13:0] a_b;
    logic [1:0]  qa, va, la, qb, vb, lb;

    srl_delay_bank #(.NUM_CH(2), .DEPTH(64), .OUT_REG(1), .SHARED_ADDR(1)) dut_a (
        .CLK(clk), .RST(rst), .CE(ce), .D(d), .A(a_a), .Q(qa), .Q_VALID(va), .Q_LAST(la));

    srl_delay_bank #(.NUM_CH(2), .DEPTH(128), .OUT_REG(0), .SHARED_ADDR(0)) dut_b (
        .CLK(clk), .RST(rst), .CE(ce), .D(d), .A(a_b), .Q(qb), .Q_VALID(vb), .Q_LAST(lb));

    int aa, ab0, ab1;
    int fill_a, fill_b;
    logic [1:0] hist [256];      // hist[i] = D that is i shifts deep
    logic [1:0] pa_q, pa_v, pa_l; // dut_a outputs expected after the next edge
    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [1:0] exp_q(input int fill, input int a0, input int a1);
        return {(fill > a1) ? hist[a1][1] : 1'b0, (fill > a0) ? hist[a0][0] : 1'b0};
    endfunction

    function automatic logic [1:0] exp_v(input int fill, input int a0, input int a1);
        return {fill > a1, fill > a0};
    endfunction

    function automatic logic [1:0] exp_last(input int fill, input int depth);
        return (fill == depth) ? hist[depth-1] : 2'b00;
    endfunction

    task automatic set_addr(input int x, input int y0, input int y1);
        aa = x; ab0 = y0; ab1 = y1;
        a_a = {6'd0, 6'(x)};
        a_b = {7'(y1), 7'(y0)};
        #1;
    endtask

    // One clock: drive, edge, update model, sample 1 time unit after the edge.
    task automatic step(input logic ce_i, input logic [1:0] d_i);
        ce = ce_i; d = d_i;
        pa_q = exp_q(fill_a, aa, aa);
        pa_v = exp_v(fill_a, aa, aa);
        pa_l = exp_last(fill_a, 64);
        @(posedge clk);
        if (ce_i) begin
            for (int i = 255; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = d_i;
            if (fill_a < 64)  fill_a++;
            if (fill_b < 128) fill_b++;
        end
        #1;
    endtask

    task automatic do_reset();
        ce = 1'b0; rst = 1'b1; fill_a = 0; fill_b = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        ce = 1'b0; d = 2'b00; rst = 1'b1;
        for (int i = 0; i < 256; i++) hist[i] = 2'b00;
        fill_a = 0; fill_b = 0;
        set_addr(0, 0, 0);
        repeat (2) @(posedge clk);
        #2;
        n_checks += 6;
        if (qa !== 2'b00) begin n_fail++; $display("FAIL reset_qa: got %b want 00", qa); end
        if (va !== 2'b00) begin n_fail++; $display("FAIL reset_va: got %b want 00", va); end
        if (la !== 2'b00) begin n_fail++; $display("FAIL reset_la: got %b want 00", la); end
        if (qb !== 2'b00) begin n_fail++; $display("FAIL reset_qb: got %b want 00", qb); end
        if (vb !== 2'b00) begin n_fail++; $display("FAIL reset_vb: got %b want 00", vb); end
        if (lb !== 2'b00) begin n_fail++; $display("FAIL reset_lb: got %b want 00", lb); end
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    // Fill of 10 never exceeds address 20: everything stays masked.
    task automatic test_mask();
        set_addr(20, 20, 20);
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 2'b11);
            n_checks += 4;
            if (qa !== 2'b00) begin n_fail++; $display("FAIL mask_qa k=%0d: got %b want 00", k, qa); end
            if (va !== 2'b00) begin n_fail++; $display("FAIL mask_va k=%0d: got %b want 00", k, va); end
            if (qb !== 2'b00) begin n_fail++; $display("FAIL mask_qb k=%0d: got %b want 00", k, qb); end
            if (vb !== 2'b00) begin n_fail++; $display("FAIL mask_vb k=%0d: got %b want 00", k, vb); end
        end
    endtask

    // Single 1 on line 0 at CE-cycle 0, tap 40: comb path shows it after
    // 41 shifts (k=40), registered path one clock later (k=41).
    task automatic test_latency();
        do_reset();
        set_addr(40, 40, 40);
        for (int k = 0; k < 60; k++) begin
            step(1'b1, (k == 0) ? 2'b01 : 2'b00);
            n_checks += 4;
            if (qb !== {1'b0, k == 40}) begin n_fail++; $display("FAIL lat_qb k=%0d: got %b want %b", k, qb, {1'b0, k == 40}); end
            if (qa !== {1'b0, k == 41}) begin n_fail++; $display("FAIL lat_qa k=%0d: got %b want %b", k, qa, {1'b0, k == 41}); end
            if (vb !== ((k >= 40) ? 2'b11 : 2'b00)) begin n_fail++; $display("FAIL lat_vb k=%0d: got %b", k, vb); end
            if (va !== ((k >= 41) ? 2'b11 : 2'b00)) begin n_fail++; $display("FAIL lat_va k=%0d: got %b", k, va); end
        end
    endtask

    // Same pulse with CE low for clocks 10..16 (D toggling, must be ignored).
    task automatic test_ce_gating();
        logic ce_t;
        do_reset();
        set_addr(40, 40, 40);
        for (int t = 0; t < 60; t++) begin
            ce_t = !(t >= 10 && t < 17);
            step(ce_t, (t == 0) ? 2'b01 : (ce_t ? 2'b00 : 2'b11));
            n_checks += 4;
            if (qb !== {1'b0, t == 47}) begin n_fail++; $display("FAIL ce_qb t=%0d: got %b want %b", t, qb, {1'b0, t == 47}); end
            if (qa !== {1'b0, t == 48}) begin n_fail++; $display("FAIL ce_qa t=%0d: got %b want %b", t, qa, {1'b0, t == 48}); end
            if (vb !== ((t >= 47) ? 2'b11 : 2'b00)) begin n_fail++; $display("FAIL ce_vb t=%0d: got %b", t, vb); end
            if (va !== ((t >= 48) ? 2'b11 : 2'b00)) begin n_fail++; $display("FAIL ce_va t=%0d: got %b", t, va); end
        end
    endtask

    // 128-deep cascade, taps straddling segment boundaries, Q_LAST timing.
    task automatic test_cascade();
        do_reset();
        set_addr(63, 31, 32);
        for (int k = 0; k < 130; k++) begin
            step(1'b1, 2'($urandom_range(0, 3)));
            n_checks += 5;
            if (qb !== exp_q(fill_b, 31, 32)) begin n_fail++; $display("FAIL casc_qb k=%0d: got %b want %b", k, qb, exp_q(fill_b, 31, 32)); end
            if (lb !== exp_last(fill_b, 128)) begin n_fail++; $display("FAIL casc_lb k=%0d: got %b want %b", k, lb, exp_last(fill_b, 128)); end
            if (vb[0] !== (k >= 31)) begin n_fail++; $display("FAIL casc_vb k=%0d: got %b", k, vb); end
            if (qa !== pa_q) begin n_fail++; $display("FAIL casc_qa k=%0d: got %b want %b", k, qa, pa_q); end
            if (la !== pa_l) begin n_fail++; $display("FAIL casc_la k=%0d: got %b want %b", k, la, pa_l); end
        end
        // Address change is visible immediately on the combinational bank.
        set_addr(63, 63, 64);
        n_checks++;
        if (qb !== exp_q(fill_b, 63, 64)) begin n_fail++; $display("FAIL casc_addr_qb: got %b want %b", qb, exp_q(fill_b, 63, 64)); end
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 2'($urandom_range(0, 3)));
            n_checks += 3;
            if (qb !== exp_q(fill_b, 63, 64)) begin n_fail++; $display("FAIL casc2_qb k=%0d: got %b want %b", k, qb, exp_q(fill_b, 63, 64)); end
            if (lb !== hist[127]) begin n_fail++; $display("FAIL casc2_lb k=%0d: got %b want %b", k, lb, hist[127]); end
            if (la !== pa_l) begin n_fail++; $display("FAIL casc2_la k=%0d: got %b want %b", k, la, pa_l); end
        end
    endtask

    // Per-line addresses 7 and 100 on the combinational bank.
    task automatic test_per_line();
        do_reset();
        set_addr(7, 7, 100);
        for (int k = 0; k < 110; k++) begin
            step(1'b1, 2'($urandom_range(0, 3)));
            n_checks += 3;
            if (vb !== {k >= 100, k >= 7}) begin n_fail++; $display("FAIL line_vb k=%0d: got %b want %b", k, vb, {k >= 100, k >= 7}); end
            if (qb !== exp_q(fill_b, 7, 100)) begin n_fail++; $display("FAIL line_qb k=%0d: got %b want %b", k, qb, exp_q(fill_b, 7, 100)); end
            if (qa !== pa_q) begin n_fail++; $display("FAIL line_qa k=%0d: got %b want %b", k, qa, pa_q); end
        end
    endtask

    // Asynchronous reset at fill 90, between edges, then refill.
    task automatic test_reset_mid();
        do_reset();
        set_addr(5, 5, 10);
        for (int k = 0; k < 90; k++) step(1'b1, 2'($urandom_range(0, 3)));
        ce = 1'b0;
        rst = 1'b1;
        fill_a = 0; fill_b = 0;
        #2;
        n_checks += 6;
        if (qa !== 2'b00) begin n_fail++; $display("FAIL mid_qa: got %b want 00", qa); end
        if (va !== 2'b00) begin n_fail++; $display("FAIL mid_va: got %b want 00", va); end
        if (la !== 2'b00) begin n_fail++; $display("FAIL mid_la: got %b want 00", la); end
        if (qb !== 2'b00) begin n_fail++; $display("FAIL mid_qb: got %b want 00", qb); end
        if (vb !== 2'b00) begin n_fail++; $display("FAIL mid_vb: got %b want 00", vb); end
        if (lb !== 2'b00) begin n_fail++; $display("FAIL mid_lb: got %b want 00", lb); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 2'($urandom_range(0, 3)));
            n_checks += 4;
            if (vb !== {k >= 10, k >= 5}) begin n_fail++; $display("FAIL mid_vb k=%0d: got %b want %b", k, vb, {k >= 10, k >= 5}); end
            if (va !== ((k >= 6) ? 2'b11 : 2'b00)) begin n_fail++; $display("FAIL mid_va k=%0d: got %b", k, va); end
            if (qb !== exp_q(fill_b, 5, 10)) begin n_fail++; $display("FAIL mid_qb k=%0d: got %b want %b", k, qb, exp_q(fill_b, 5, 10)); end
            if (qa !== pa_q) begin n_fail++; $display("FAIL mid_qa k=%0d: got %b want %b", k, qa, pa_q); end
        end
    endtask

    initial begin
        test_reset();
        test_mask();
        test_latency();
        test_ce_gating();
        test_cascade();
        test_per_line();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
